// File: rtl/fetch_issue.sv
// Instruction fetch and issue sequencer: owns the PC, fetches words over imem req/ack,
// offers them to decode over valid/ready, and stalls on control flow until execute resolves it.
module fetch_issue #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,

    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,

    output logic                id_valid,
    input  logic                id_ready,
    output logic [31:0]         id_instr,
    output logic [5:0]          id_op,
    output logic [PC_WIDTH-1:0] id_pc,

    input  logic                br_resolve,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,

    output logic                illegal,
    output logic [31:0]         issue_count
);

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

    localparam logic [5:0] OP_ADD      = 6'd0;
    localparam logic [5:0] OP_SUB      = 6'd1;
    localparam logic [5:0] OP_MUL      = 6'd2;
    localparam logic [5:0] OP_AND      = 6'd3;
    localparam logic [5:0] OP_OR       = 6'd4;
    localparam logic [5:0] OP_LBD      = 6'd10;
    localparam logic [5:0] OP_LDW      = 6'd11;
    localparam logic [5:0] OP_STB      = 6'd12;
    localparam logic [5:0] OP_STW      = 6'd13;
    localparam logic [5:0] OP_MOV      = 6'd14;
    localparam logic [5:0] OP_BEQ      = 6'd20;
    localparam logic [5:0] OP_JUMP     = 6'd21;
    localparam logic [5:0] OP_TLBWRITE = 6'd30;
    localparam logic [5:0] OP_IRET     = 6'd31;

    typedef enum logic [1:0] {
        S_FETCH,
        S_ISSUE,
        S_BRWAIT,
        S_HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_legal;
    logic                issue_is_ctrl;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
            OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
            OP_BEQ, OP_JUMP, OP_IRET, OP_TLBWRITE: is_legal = 1'b1;
            default:                               is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_ctrl(input logic [5:0] op);
        case (op)
            OP_BEQ, OP_JUMP, OP_IRET: is_ctrl = 1'b1;
            default:                  is_ctrl = 1'b0;
        endcase
    endfunction

    assign fetch_legal   = is_legal(imem_rdata[31:26]);
    assign issue_is_ctrl = is_ctrl(id_instr[31:26]);

    // Request is gated by rst_n so no fetch is advertised while reset is held.
    assign imem_req  = rst_n && (state == S_FETCH);
    assign imem_addr = pc;
    assign id_op     = id_instr[31:26];

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below reads the pre-edge values of pc, state and id_instr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            illegal     <= 1'b0;
            issue_count <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (fetch_legal) begin
                            id_instr <= imem_rdata;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            illegal  <= 1'b1;
                            state    <= S_HALT;
                        end
                    end
                end

                S_ISSUE: begin
                    if (id_ready) begin
                        id_valid    <= 1'b0;
                        issue_count <= issue_count + 32'd1;
                        if (issue_is_ctrl) begin
                            state <= S_BRWAIT;
                        end else begin
                            pc    <= pc + PC_INC;
                            state <= S_FETCH;
                        end
                    end
                end

                // PC stays at the control-flow instruction until execute decides.
                S_BRWAIT: begin
                    if (br_resolve) begin
                        pc    <= br_taken ? br_target : pc + PC_INC;
                        state <= S_FETCH;
                    end
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// Self-checking bench for fetch_issue: directed sequences, an opcode table, and
// randomized runs compared against a program-walk model of fetch/issue order.
module tb_fetch_issue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, 32-bit PC from 0
    logic        rst_n, imem_req, imem_ack, id_valid, id_ready;
    logic        br_resolve, br_taken, illegal;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, br_target, issue_count;
    logic [5:0]  id_op;

    // Narrow instance for PC wrap-around
    logic        w_rst_n, w_imem_req, w_imem_ack, w_id_valid, w_id_ready;
    logic        w_br_resolve, w_br_taken, w_illegal;
    logic [7:0]  w_imem_addr, w_id_pc, w_br_target;
    logic [31:0] w_imem_rdata, w_id_instr, w_issue_count;
    logic [5:0]  w_id_op;

    fetch_issue #(.PC_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_op(id_op), .id_pc(id_pc),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
        .illegal(illegal), .issue_count(issue_count)
    );

    fetch_issue #(.PC_WIDTH(8), .RESET_PC(8'hFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
        .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr), .id_op(w_id_op), .id_pc(w_id_pc),
        .br_resolve(w_br_resolve), .br_taken(w_br_taken), .br_target(w_br_target),
        .illegal(w_illegal), .issue_count(w_issue_count)
    );

    localparam logic [31:0] W_ADD  = 32'h0000_0123;
    localparam logic [31:0] W_SUB  = 32'h0400_0456;
    localparam logic [31:0] W_LDW  = 32'h2C00_0000;
    localparam logic [31:0] W_BEQ  = 32'h5000_0008;
    localparam logic [31:0] W_JUMP = 32'h5400_0010;
    localparam logic [31:0] W_ILL  = 32'h1C00_0020;
    localparam int          RUN_LIMIT = 4000;

    typedef struct {
        logic [5:0]  op;
        logic        exp_illegal;
        logic        exp_valid;
        logic        exp_req;
        logic [31:0] exp_count;
    } vec_t;

    typedef struct {
        bit          taken;
        logic [31:0] target;
    } dec_t;

    int n_vec  = 0;
    int n_fail = 0;

    logic [5:0]  legal_ops [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd10, 6'd11,
                                    6'd12, 6'd13, 6'd14, 6'd20, 6'd21, 6'd30, 6'd31};
    logic [31:0] mem [bit [31:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_cf(input logic [5:0] op);
        return (op == 6'd20) || (op == 6'd21) || (op == 6'd31);
    endfunction

    // Program memory filled on first touch; mostly legal opcodes, occasional undefined one.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] op;
        if (!mem.exists(a)) begin
            if ($urandom_range(0, 99) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (op_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 13)];
            end
            mem[a] = {op, 26'($urandom())};
        end
        return mem[a];
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = $urandom();
        id_ready   = 1'b1;
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        br_target  = $urandom();
        tick();
        check("rst_valid", 64'(id_valid), 64'(0));
        check("rst_illegal", 64'(illegal), 64'(0));
        check("rst_count", 64'(issue_count), 64'(0));
        check("rst_req", 64'(imem_req), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        rst_n      = 1'b1;
        imem_ack   = 1'b0;
        id_ready   = 1'b0;
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        #1;
    endtask

    task automatic random_run(input int run);
        int          cycles, n_issued, di, mi;
        bit          in_brwait, cf_acc, res_now, hold_v, hold_f, exp_ill;
        logic [31:0] hold_pc, hold_instr, hold_addr, pc, w;
        logic [31:0] obs_fetch[$], obs_pc[$], obs_instr[$];
        logic [31:0] exp_fetch[$], exp_pc[$], exp_instr[$];
        dec_t        decs[$];

        mem.delete();
        for (int i = 0; i < 400; i++) begin
            dec_t d;
            d.taken  = 1'($urandom_range(0, 1));
            d.target = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 9) == 0) d.target = d.target | 32'd1;
            decs.push_back(d);
        end

        do_reset();
        cycles = 0; n_issued = 0; di = 0;
        in_brwait = 0; cf_acc = 0; res_now = 0; hold_v = 0; hold_f = 0;
        hold_pc = '0; hold_instr = '0; hold_addr = '0;

        while (n_issued < 120 && !illegal && cycles < RUN_LIMIT) begin
            if (cf_acc)  in_brwait = 1'b1;
            if (res_now) in_brwait = 1'b0;
            cf_acc = 0; res_now = 0;

            if (hold_v) begin
                check("stall_valid", 64'(id_valid), 64'(1));
                check("stall_pc", 64'(id_pc), 64'(hold_pc));
                check("stall_instr", 64'(id_instr), 64'(hold_instr));
            end
            if (hold_f) begin
                check("fetch_hold_req", 64'(imem_req), 64'(1));
                check("fetch_hold_addr", 64'(imem_addr), 64'(hold_addr));
            end
            if (in_brwait) check("brwait_quiet", 64'({imem_req, id_valid}), 64'(0));

            imem_ack   = ($urandom_range(0, 3) != 0);
            imem_rdata = (imem_ack && imem_req) ? mem_word(imem_addr) : $urandom();
            id_ready   = ($urandom_range(0, 2) != 0);
            if (in_brwait) begin
                br_resolve = ($urandom_range(0, 2) == 0);
                br_taken   = 1'($urandom_range(0, 1));
                br_target  = $urandom();
                if (br_resolve) begin
                    br_taken  = decs[di].taken;
                    br_target = decs[di].target;
                    di++;
                    res_now = 1;
                end
            end else begin
                br_resolve = ($urandom_range(0, 7) == 0);
                br_taken   = 1'($urandom_range(0, 1));
                br_target  = $urandom();
            end

            if (imem_req && imem_ack) obs_fetch.push_back(imem_addr);
            if (id_valid && id_ready) begin
                obs_pc.push_back(id_pc);
                obs_instr.push_back(id_instr);
                n_issued++;
                if (op_cf(id_instr[31:26])) cf_acc = 1;
            end
            hold_v = id_valid && !id_ready;
            hold_pc = id_pc; hold_instr = id_instr;
            hold_f = imem_req && !imem_ack;
            hold_addr = imem_addr;

            tick();
            cycles++;
        end
        check($sformatf("run%0d_progress", run), 64'(cycles < RUN_LIMIT), 64'(1));
        imem_ack = 0; id_ready = 0; br_resolve = 0;

        // Walk the program: each fetch follows from the previous instruction and the branch decisions.
        pc = 32'h0; mi = 0; exp_ill = 0;
        for (int k = 0; k < obs_fetch.size(); k++) begin
            w = mem_word(pc);
            exp_fetch.push_back(pc);
            if (!op_legal(w[31:26])) begin
                exp_ill = 1;
                break;
            end
            exp_pc.push_back(pc);
            exp_instr.push_back(w);
            if (op_cf(w[31:26])) begin
                pc = decs[mi].taken ? decs[mi].target : pc + 32'd4;
                mi++;
            end else begin
                pc = pc + 32'd4;
            end
        end

        check($sformatf("run%0d_nfetch", run), 64'(obs_fetch.size()), 64'(exp_fetch.size()));
        for (int k = 0; k < obs_fetch.size() && k < exp_fetch.size(); k++)
            check($sformatf("run%0d_fetch%0d", run, k), 64'(obs_fetch[k]), 64'(exp_fetch[k]));
        check($sformatf("run%0d_nissue", run),
              64'((n_issued == exp_pc.size()) || (n_issued + 1 == exp_pc.size())), 64'(1));
        for (int k = 0; k < n_issued && k < exp_pc.size(); k++)
            check($sformatf("run%0d_issue%0d", run, k),
                  {obs_pc[k], obs_instr[k]}, {exp_pc[k], exp_instr[k]});
        check($sformatf("run%0d_count", run), 64'(issue_count), 64'(n_issued));
        check($sformatf("run%0d_illegal", run), 64'(illegal), 64'(exp_ill));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [16];

        rst_n = 0; imem_ack = 0; imem_rdata = '0; id_ready = 0;
        br_resolve = 0; br_taken = 0; br_target = '0;
        w_rst_n = 0; w_imem_ack = 0; w_imem_rdata = 32'h0000_0001; w_id_ready = 1;
        w_br_resolve = 0; w_br_taken = 0; w_br_target = '0;

        // Wrap-around: PC_WIDTH=8 from 0xFC
        tick();
        w_rst_n = 1; w_imem_ack = 1;
        #1;
        check("wrap_first_addr", 64'(w_imem_addr), 64'(8'hFC));
        check("wrap_first_req", 64'(w_imem_req), 64'(1));
        tick();
        check("wrap_valid", 64'(w_id_valid), 64'(1));
        check("wrap_id_pc", 64'(w_id_pc), 64'(8'hFC));
        check("wrap_id_op", 64'({w_id_op, w_id_instr}), 64'({6'd0, 32'h0000_0001}));
        tick();
        check("wrap_second_addr", 64'(w_imem_addr), 64'(8'h00));
        check("wrap_count", 64'({w_illegal, w_issue_count}), 64'(1));
        w_imem_ack = 0;

        // Reset, then ADD at 0x0 and SUB at 0x4
        rst_n = 0; imem_ack = 1; imem_rdata = W_SUB; br_resolve = 1; br_taken = 1; br_target = 32'h80;
        tick();
        check("reset_valid", 64'(id_valid), 64'(0));
        check("reset_payload", {id_instr, id_pc}, 64'(0));
        check("reset_op", 64'(id_op), 64'(0));
        check("reset_illegal", 64'(illegal), 64'(0));
        check("reset_count", 64'(issue_count), 64'(0));
        check("reset_req", 64'(imem_req), 64'(0));
        rst_n = 1; imem_rdata = W_ADD; br_resolve = 0; id_ready = 1;
        #1;
        check("seq_req0", 64'(imem_req), 64'(1));
        check("seq_addr0", 64'(imem_addr), 64'(0));
        tick();
        check("seq_valid0", 64'(id_valid), 64'(1));
        check("seq_issue0", {id_pc, id_instr}, {32'h0, W_ADD});
        check("seq_op0", 64'(id_op), 64'(0));
        check("seq_noreq_issue", 64'(imem_req), 64'(0));
        imem_rdata = W_SUB;
        tick();
        check("seq_valid_gap", 64'(id_valid), 64'(0));
        check("seq_addr1", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h4}));
        check("seq_count1", 64'(issue_count), 64'(1));
        tick();
        check("seq_valid1", 64'(id_valid), 64'(1));
        check("seq_issue1", {id_pc, id_instr}, {32'h4, W_SUB});
        imem_rdata = W_BEQ;
        tick();
        check("seq_count2", 64'(issue_count), 64'(2));
        check("seq_addr2", 64'(imem_addr), 64'(8));

        // Taken branch at 0x8 resolved three cycles after accept
        tick();
        check("beq_op", 64'({id_op, id_pc}), 64'({6'd20, 32'h8}));
        tick();
        check("beq_count", 64'(issue_count), 64'(3));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("beq_wait%0d", i), 64'({imem_req, id_valid}), 64'(0));
            if (i == 2) begin
                br_resolve = 1; br_taken = 1; br_target = 32'h40;
                imem_rdata = W_LDW; id_ready = 0;
            end
            tick();
        end
        br_resolve = 0;
        check("beq_target", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h40}));

        // Decode backpressure on LDW
        tick();
        check("bp_first", {id_pc, id_instr}, {32'h40, W_LDW});
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_valid%0d", i), 64'(id_valid), 64'(1));
            check($sformatf("bp_payload%0d", i), {id_pc, id_instr}, {32'h40, W_LDW});
            check($sformatf("bp_noreq%0d", i), 64'(imem_req), 64'(0));
            check($sformatf("bp_count%0d", i), 64'(issue_count), 64'(3));
        end
        id_ready = 1;
        tick();
        check("bp_count_after", 64'(issue_count), 64'(4));
        check("bp_next_addr", 64'(imem_addr), 64'(32'h44));

        // Spurious resolve in FETCH, then taken BEQ to 0x10 in the minimum 3-cycle loop
        imem_ack = 0; br_resolve = 1; br_taken = 1; br_target = 32'h80;
        tick();
        check("spur1_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h44}));
        br_resolve = 0; imem_ack = 1; imem_rdata = W_BEQ;
        tick();
        tick();
        br_resolve = 1; br_taken = 1; br_target = 32'h10;
        tick();
        check("loop3_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h10}));
        imem_ack = 0; br_resolve = 1; br_taken = 1; br_target = 32'h80;
        tick();
        check("spur2_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h10}));
        br_resolve = 0; imem_ack = 1; imem_rdata = W_JUMP;
        tick();
        check("jump_op", 64'({id_op, id_pc}), 64'({6'd21, 32'h10}));
        tick();
        br_resolve = 1; br_taken = 0; br_target = 32'h80;
        tick();
        br_resolve = 0;
        check("jump_nt_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h14}));
        check("jump_count", 64'(issue_count), 64'(6));

        // JUMP at 0x14 taken to 0x20, then undefined opcode 7 there
        tick();
        tick();
        br_resolve = 1; br_taken = 1; br_target = 32'h20;
        tick();
        br_resolve = 0; imem_rdata = W_ILL;
        check("ill_addr", 64'(imem_addr), 64'(32'h20));
        tick();
        check("ill_flag", 64'(illegal), 64'(1));
        check("ill_quiet", 64'({imem_req, id_valid}), 64'(0));
        imem_rdata = W_ADD; br_resolve = 1; br_taken = 1; br_target = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("halt_hold%0d", i), 64'({illegal, imem_req, id_valid}), 64'(3'b100));
            check($sformatf("halt_count%0d", i), 64'(issue_count), 64'(7));
        end
        rst_n = 0;
        tick();
        check("halt_reset_illegal", 64'(illegal), 64'(0));
        check("halt_reset_count", 64'(issue_count), 64'(0));
        rst_n = 1; br_resolve = 0;
        #1;
        check("halt_refetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));

        // Opcode table: legality, issue, and whether control flow parks the fetcher
        vecs[0]  = '{6'd0,  1'b0, 1'b1, 1'b1, 32'd1};
        vecs[1]  = '{6'd4,  1'b0, 1'b1, 1'b1, 32'd1};
        vecs[2]  = '{6'd5,  1'b1, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{6'd9,  1'b1, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{6'd10, 1'b0, 1'b1, 1'b1, 32'd1};
        vecs[5]  = '{6'd14, 1'b0, 1'b1, 1'b1, 32'd1};
        vecs[6]  = '{6'd15, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{6'd19, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{6'd20, 1'b0, 1'b1, 1'b0, 32'd1};
        vecs[9]  = '{6'd21, 1'b0, 1'b1, 1'b0, 32'd1};
        vecs[10] = '{6'd22, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[11] = '{6'd29, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[12] = '{6'd30, 1'b0, 1'b1, 1'b1, 32'd1};
        vecs[13] = '{6'd31, 1'b0, 1'b1, 1'b0, 32'd1};
        vecs[14] = '{6'd32, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[15] = '{6'd63, 1'b1, 1'b0, 1'b0, 32'd0};
        for (int i = 0; i < 16; i++) begin
            do_reset();
            imem_ack = 1; imem_rdata = {vecs[i].op, 26'($urandom())}; id_ready = 1;
            tick();
            check($sformatf("tbl_op%0d_illegal", vecs[i].op), 64'(illegal), 64'(vecs[i].exp_illegal));
            check($sformatf("tbl_op%0d_valid", vecs[i].op), 64'(id_valid), 64'(vecs[i].exp_valid));
            imem_ack = 0;
            tick();
            check($sformatf("tbl_op%0d_req", vecs[i].op), 64'(imem_req), 64'(vecs[i].exp_req));
            check($sformatf("tbl_op%0d_count", vecs[i].op), 64'(issue_count), 64'(vecs[i].exp_count));
        end

        for (int r = 0; r < 4; r++) random_run(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
